// File: rtl/issue_queue.sv
// In-order circular issue queue between decode and issue.
// Optional same-cycle bypass when empty: define IQ_BYPASS_EN.
module issue_queue #(
  parameter int DEPTH = 8,
  parameter int ILEN  = 32,
  parameter int XLEN  = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [ILEN-1:0]            instr_i,
  input  logic [XLEN-1:0]            pc_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [ILEN-1:0]            instr_o,
  output logic [XLEN-1:0]            pc_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [ILEN-1:0] NOP = ILEN'(32'h13);

  logic [ILEN-1:0] instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic take;
  logic store;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign ready_o = !full;
  assign count_o = count;
  assign push    = valid_i & ready_o;
  assign pop     = !empty & ready_i;

`ifdef IQ_BYPASS_EN
  logic bypass;
  assign bypass  = empty & !flush_i;
  assign take    = bypass & valid_i & ready_i;
  assign valid_o = bypass ? valid_i : !empty;
`else
  assign take    = 1'b0;
  assign valid_o = !empty;
`endif

  assign store = push & !take;

  // Head view: stored head, bypassed input, or NOP/0 when nothing valid.
  always_comb begin
    instr_o = NOP;
    pc_o    = '0;
    if (!empty) begin
      instr_o = instr_q[head];
      pc_o    = pc_q[head];
    end
`ifdef IQ_BYPASS_EN
    else if (bypass && valid_i) begin
      instr_o = instr_i;
      pc_o    = pc_i;
    end
`endif
  end

  // Storage write at the tail; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (store && !flush_i) begin
      instr_q[tail] <= instr_i;
      pc_q[tail]    <= pc_i;
    end
  end

  // Pointers and occupancy; flush outranks push and pop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (store) tail <= nxt(tail);
      if (pop)   head <= nxt(head);
      unique case ({store, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
